mips32_fetch_unit: RTL

- Parametrised fetch/next-PC unit for the MIPS32 SOC core. It replaces the combinational `nextPC = PC + 4` path with a sequential block.
- Owns the PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Holds each fetched instruction until execute consumes it, then resolves jump/BEQ/BNE.
- Traps on invalid opcode or fetch timeout: vectors to a fixed exception address and records the EPC.

---
 rtl/mips32_pkg.sv | 24 ++
 rtl/mips32_next_pc.sv | 44 ++++
 rtl/mips32_fetch_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// ============================================================================
// mips32_pkg : shared types and constants for the MIPS32 fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mips32_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    TRAP  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_INV_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

`default_nettype wire

// File: rtl/mips32_next_pc.sv
// ============================================================================
// mips32_next_pc : combinational jump/BEQ/BNE target resolver
// Rev 1.0
// ============================================================================
`default_nettype none

module mips32_next_pc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] inst_pc,
  input  logic [25:0]       jidx,
  input  logic [31:0]       imm32,
  input  logic              is_jmp,
  input  logic              is_beq,
  input  logic              is_bne,
  input  logic              is_zero,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;

  assign pc4    = inst_pc + ADDR_W'(4);
  assign br_tgt = pc4 + ADDR_W'(imm32 << 2);

  // A 28-bit PC has no segment bits above the 26-bit jump index.
  if (ADDR_W > 28) begin : g_jmp_hi
    assign jmp_tgt = {pc4[ADDR_W-1:28], jidx, 2'b00};
  end else begin : g_jmp_lo
    assign jmp_tgt = {jidx, 2'b00};
  end

  always_comb begin
    target = pc4;
    if (is_jmp)
      target = jmp_tgt;
    else if ((is_beq && is_zero) || (is_bne && !is_zero))
      target = br_tgt;
  end

endmodule

`default_nettype wire

// File: rtl/mips32_fetch_unit.sv
// ============================================================================
// mips32_fetch_unit : sequential PC/fetch FSM with req/ack imem and traps
// Rev 1.0
// ============================================================================
`default_nettype none

module mips32_fetch_unit
  import mips32_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                IMEM_AW    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR),
  parameter int                MAX_WAIT   = 15
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_data,
  output logic [31:0]        inst,
  output logic               inst_valid,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               ex_done,
  input  logic               stall,
  input  logic               is_jmp,
  input  logic               is_beq,
  input  logic               is_bne,
  input  logic               is_zero,
  input  logic               invalid_opcode,
  input  logic [31:0]        imm32,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [ADDR_W-1:0]  epc,
  output logic               halted
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
  logic [31:0]       inst_n;
  logic [ADDR_W-1:0] inst_pc_n;
  logic [1:0]        trap_cause_n;
  logic [ADDR_W-1:0] epc_n;
  logic [ADDR_W-1:0] target;

  mips32_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .inst_pc (inst_pc),
    .jidx    (inst[25:0]),
    .imm32   (imm32),
    .is_jmp  (is_jmp),
    .is_beq  (is_beq),
    .is_bne  (is_bne),
    .is_zero (is_zero),
    .target  (target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      wait_cnt   <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      trap_cause <= CAUSE_NONE;
      epc        <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      wait_cnt   <= wait_cnt_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      trap_cause <= trap_cause_n;
      epc        <= epc_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    wait_cnt_n   = wait_cnt;
    inst_n       = inst;
    inst_pc_n    = inst_pc;
    trap_cause_n = trap_cause;
    epc_n        = epc;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          inst_n     = imem_data;
          inst_pc_n  = pc;
          wait_cnt_n = '0;
          state_n    = ISSUE;
        end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          wait_cnt_n   = '0;
          trap_cause_n = CAUSE_FETCH_TO;
          epc_n        = pc;
          state_n      = TRAP;
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end
      ISSUE: begin
        if (ex_done && !stall) begin
          if (invalid_opcode) begin
            trap_cause_n = CAUSE_INV_OPC;
            epc_n        = inst_pc;
            state_n      = TRAP;
          end else begin
            pc_n    = target;
            state_n = FETCH;
          end
        end
      end
      TRAP: begin
        pc_n = EXC_VECTOR;
        // A timeout fetching the vector itself would retrap forever.
        if (trap_cause == CAUSE_FETCH_TO && epc == EXC_VECTOR)
          state_n = HALT;
        else
          state_n = FETCH;
      end
      default: state_n = HALT;
    endcase
  end

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc[IMEM_AW+1:2];
  assign inst_valid = (state == ISSUE);
  assign trap       = (state == TRAP);
  assign halted     = (state == HALT);

endmodule

`default_nettype wire
